div_job_queue: RTL and testbench

//  Upstream command stage for the sequential divider peripheral. Accepts CPU-queued {divisor, dividend} jobs,

---
 rtl/div_job_queue_pkg.sv | 38 +++
 rtl/div_job_queue_if.sv | 23 ++
 rtl/div_job_queue_fifo.sv | 58 +++++
 rtl/div_job_queue.sv | 206 ++++++++++++++++++++
 tb/tb_div_job_queue.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/div_job_queue_pkg.sv
// Shared constants for the divider job queue: the divider's register map, the CPU-facing
// register map, engine FSM states and STATUS bit positions. Package name: div_pkg.
package div_pkg;

    localparam logic [7:0] DIV_INFO = 8'h00;
    localparam logic [7:0] DIV_END  = 8'h04;
    localparam logic [7:0] DIV_SOR  = 8'h08;
    localparam logic [7:0] DIV_QUO  = 8'h0C;
    localparam logic [7:0] DIV_REM  = 8'h10;

    localparam logic [7:0] REG_STATUS   = 8'h00;
    localparam logic [7:0] REG_DIVISOR  = 8'h04;
    localparam logic [7:0] REG_DIVIDEND = 8'h08;
    localparam logic [7:0] REG_QUO      = 8'h0C;
    localparam logic [7:0] REG_REM      = 8'h10;
    localparam logic [7:0] REG_POP      = 8'h14;

    localparam int STAT_JOB_EMPTY = 0;
    localparam int STAT_JOB_FULL  = 1;
    localparam int STAT_RES_EMPTY = 2;
    localparam int STAT_RES_FULL  = 3;
    localparam int STAT_BUSY      = 4;
    localparam int STAT_OVF       = 5;
    localparam int STAT_UNF       = 6;
    localparam int STAT_HEAD_DZ   = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_END,
        ST_WR_SOR,
        ST_GAP,
        ST_POLL,
        ST_RD_QUO,
        ST_RD_REM,
        ST_PUSH
    } state_e;

endpackage

// File: rtl/div_job_queue_if.sv
// Bus bundle of the job queue: CPU-side register port plus the divider register port it drives.
interface div_job_queue_if;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        we;
    logic        re;
    logic [7:0]  div_address;
    logic [31:0] div_write_data;
    logic [31:0] div_read_data;
    logic        div_we;
    logic        div_re;

    modport slave (
        input  address, write_data, we, re, div_read_data,
        output read_data, div_address, div_write_data, div_we, div_re
    );

    modport master (
        output address, write_data, we, re, div_read_data,
        input  read_data, div_address, div_write_data, div_we, div_re
    );
endinterface

// File: rtl/div_job_queue_fifo.sv
// Synchronous FIFO with combinational head read; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/div_job_queue.sv
// Command stage in front of the sequential divider: queues CPU jobs, runs them through the divider,
// queues results. Optional feature macro: DIVQ_ZERO_BYPASS_EN (divide-by-zero jobs skip the divider).
module div_job_queue
    import div_pkg::*;
#(
    parameter int JOB_DEPTH = 4,
    parameter int RES_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    div_job_queue_if.slave bus
);
    localparam int JAW = $clog2(JOB_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
`ifdef DIVQ_ZERO_BYPASS_EN
    localparam int RES_W = 65;
`else
    localparam int RES_W = 64;
`endif

    state_e      state_q, state_d;
    logic [31:0] divisor_q, divisor_d, last_dividend_q, last_dividend_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0] hold_divisor_q, hold_divisor_d, hold_dividend_q, hold_dividend_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d;
`ifdef DIVQ_ZERO_BYPASS_EN
    logic        dz_q, dz_d;
`endif

    logic             job_pop, job_full, job_empty;
    logic [63:0]      job_rdata;
    logic [JAW:0]     job_count;
    logic             res_push, res_full, res_empty;
    logic [RES_W-1:0] res_wdata, res_rdata;
    logic [RAW:0]     res_count;
    logic             wr_status, wr_divisor, wr_dividend, wr_pop;
    logic             head_dz;
    logic [31:0]      status;
    logic             unused_re;
    logic [7:0]       div_address;
    logic [31:0]      div_write_data;
    logic             div_we, div_re;

    assign unused_re   = bus.re;
    assign wr_status   = bus.we && (bus.address == REG_STATUS);
    assign wr_divisor  = bus.we && (bus.address == REG_DIVISOR);
    assign wr_dividend = bus.we && (bus.address == REG_DIVIDEND);
    assign wr_pop      = bus.we && (bus.address == REG_POP);

    sync_fifo #(.WIDTH(64), .DEPTH(JOB_DEPTH)) u_job_fifo (
        .clk(clk), .rst(rst), .push(wr_dividend), .pop(job_pop),
        .wdata({divisor_q, bus.write_data}), .rdata(job_rdata),
        .full(job_full), .empty(job_empty), .count(job_count)
    );

    sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk(clk), .rst(rst), .push(res_push), .pop(wr_pop),
        .wdata(res_wdata), .rdata(res_rdata),
        .full(res_full), .empty(res_empty), .count(res_count)
    );

`ifdef DIVQ_ZERO_BYPASS_EN
    assign res_wdata = {dz_q, quo_q, rem_q};
    assign head_dz   = res_rdata[64] & ~res_empty;
`else
    assign res_wdata = {quo_q, rem_q};
    assign head_dz   = 1'b0;
`endif

    always_comb begin
        status                 = '0;
        status[STAT_JOB_EMPTY] = job_empty;
        status[STAT_JOB_FULL]  = job_full;
        status[STAT_RES_EMPTY] = res_empty;
        status[STAT_RES_FULL]  = res_full;
        status[STAT_BUSY]      = (state_q != ST_IDLE);
        status[STAT_OVF]       = ovf_q;
        status[STAT_UNF]       = unf_q;
        status[STAT_HEAD_DZ]   = head_dz;
        status[15:8]           = 8'(job_count);
        status[23:16]          = 8'(res_count);
    end

    always_comb begin
        bus.read_data = '0;
        case (bus.address)
            REG_STATUS:   bus.read_data = status;
            REG_DIVISOR:  bus.read_data = divisor_q;
            REG_DIVIDEND: bus.read_data = last_dividend_q;
            REG_QUO:      bus.read_data = res_empty ? 32'h0 : res_rdata[63:32];
            REG_REM:      bus.read_data = res_empty ? 32'h0 : res_rdata[31:0];
            default:      bus.read_data = '0;
        endcase
    end

    // Sticky flags: set on a rejected access, cleared by W1C on STATUS.
    always_comb begin
        divisor_d       = wr_divisor  ? bus.write_data : divisor_q;
        last_dividend_d = wr_dividend ? bus.write_data : last_dividend_q;
        ovf_d = (ovf_q & ~(wr_status & bus.write_data[STAT_OVF])) | (wr_dividend & job_full);
        unf_d = (unf_q & ~(wr_status & bus.write_data[STAT_UNF])) | (wr_pop & res_empty);
    end

    always_comb begin
        state_d         = state_q;
        job_pop         = 1'b0;
        res_push        = 1'b0;
        div_we          = 1'b0;
        div_re          = 1'b0;
        div_address     = '0;
        div_write_data  = '0;
        hold_divisor_d  = hold_divisor_q;
        hold_dividend_d = hold_dividend_q;
        quo_d           = quo_q;
        rem_d           = rem_q;
`ifdef DIVQ_ZERO_BYPASS_EN
        dz_d            = dz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!job_empty && !res_full) begin
                    job_pop         = 1'b1;
                    hold_divisor_d  = job_rdata[63:32];
                    hold_dividend_d = job_rdata[31:0];
                    state_d         = ST_WR_END;
`ifdef DIVQ_ZERO_BYPASS_EN
                    dz_d = 1'b0;
                    if (job_rdata[63:32] == 32'h0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rem_d   = job_rdata[31:0];
                        dz_d    = 1'b1;
                        state_d = ST_PUSH;
                    end
`endif
                end
            end
            ST_WR_END: begin
                div_we         = 1'b1;
                div_address    = DIV_END;
                div_write_data = hold_divisor_q;
                state_d        = ST_WR_SOR;
            end
            ST_WR_SOR: begin
                div_we         = 1'b1;
                div_address    = DIV_SOR;
                div_write_data = hold_dividend_q;
                state_d        = ST_GAP;
            end
            // The divider's busy flag lags the SOR write by one cycle.
            ST_GAP: state_d = ST_POLL;
            ST_POLL: begin
                div_re      = 1'b1;
                div_address = DIV_INFO;
                if (bus.div_read_data[0]) state_d = ST_RD_QUO;
            end
            ST_RD_QUO: begin
                div_re      = 1'b1;
                div_address = DIV_QUO;
                quo_d       = bus.div_read_data;
                state_d     = ST_RD_REM;
            end
            ST_RD_REM: begin
                div_re      = 1'b1;
                div_address = DIV_REM;
                rem_d       = bus.div_read_data;
                state_d     = ST_PUSH;
            end
            ST_PUSH: begin
                res_push = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.div_address    = div_address;
    assign bus.div_write_data = div_write_data;
    assign bus.div_we         = div_we;
    assign bus.div_re         = div_re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            divisor_q       <= '0;
            last_dividend_q <= '0;
            ovf_q           <= 1'b0;
            unf_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            divisor_q       <= divisor_d;
            last_dividend_q <= last_dividend_d;
            ovf_q           <= ovf_d;
            unf_q           <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_divisor_q  <= hold_divisor_d;
        hold_dividend_q <= hold_dividend_d;
        quo_q           <= quo_d;
        rem_q           <= rem_d;
`ifdef DIVQ_ZERO_BYPASS_EN
        dz_q            <= dz_d;
`endif
    end
endmodule

// File: tb/tb_div_job_queue.sv
// Bench for div_job_queue with a behavioural divider peripheral and a result scoreboard.
module tb_div_job_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
    } res_t;
    res_t sb[$];

    div_job_queue_if dif();
    div_job_queue dut (.clk(clk), .rst(rst), .bus(dif));

    always #5 clk = ~clk;

    // Divider peripheral: INFO[0]=1 when idle, 31 busy cycles after a SOR write.
    logic [31:0] dv_end = '0, dv_quo = '0, dv_rem = '0;
    int          dv_cnt = 0;
    int          we_cnt = 0;
    always @(posedge clk) begin
        if (dif.div_we) we_cnt <= we_cnt + 1;
        if (dif.div_we && dif.div_address == 8'h04) dv_end <= dif.div_write_data;
        if (dif.div_we && dif.div_address == 8'h08) begin
            if (dv_end == 32'h0) begin
                dv_quo <= 32'hFFFF_FFFF;
                dv_rem <= dif.div_write_data;
            end else begin
                dv_quo <= dif.div_write_data / dv_end;
                dv_rem <= dif.div_write_data % dv_end;
            end
            dv_cnt <= 31;
        end else if (dv_cnt > 0) begin
            dv_cnt <= dv_cnt - 1;
        end
    end
    always_comb begin
        dif.div_read_data = 32'h0;
        case (dif.div_address)
            8'h00: dif.div_read_data = {31'h0, dv_cnt == 0};
            8'h04: dif.div_read_data = dv_end;
            8'h0C: dif.div_read_data = dv_quo;
            8'h10: dif.div_read_data = dv_rem;
            default: dif.div_read_data = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        dif.address    = a;
        dif.write_data = d;
        dif.we         = 1'b1;
        @(negedge clk);
        dif.we         = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        dif.address = a;
        dif.re      = 1'b1;
        #1;
        d           = dif.read_data;
        dif.re      = 1'b0;
    endtask

    task automatic push_job(input logic [31:0] dvs, input logic [31:0] dvd,
                            input logic [31:0] eq, input logic [31:0] er, input bit track);
        wr(8'h04, dvs);
        wr(8'h08, dvd);
        if (track) sb.push_back('{q: eq, r: er});
    endtask

    task automatic wait_res(input int min_cnt, input int max_cyc, output int cyc, output bit ok);
        logic [31:0] s;
        ok  = 1'b0;
        cyc = 0;
        rd(8'h00, s);
        while (!ok && cyc < max_cyc) begin
            if (32'(s[23:16]) >= min_cnt) ok = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
                rd(8'h00, s);
            end
        end
    endtask

    task automatic drain_one(input string tag);
        int          cyc;
        bit          ok;
        logic [31:0] q, r;
        res_t        e;
        wait_res(1, 150, cyc, ok);
        check({tag, "_wait"}, 32'(ok), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            rd(8'h0C, q);
            rd(8'h10, r);
            check({tag, "_quo"}, q, e.q);
            check({tag, "_rem"}, r, e.r);
        end
        wr(8'h14, 32'h0);
    endtask

    task automatic wait_div(input logic [7:0] a, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            if (dif.div_re && dif.div_address == a) ok = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] s;
        int          cyc;
        bit          ok;
        int          we_base;

        dif.address    = '0;
        dif.write_data = '0;
        dif.we         = 1'b0;
        dif.re         = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h00, s);
        check("reset_status", s, 32'h0000_0005);
        check("reset_div_strobes", {30'h0, dif.div_we, dif.div_re}, 32'h0);
        rst = 1'b0;
        rd(8'h04, s);
        check("reset_divisor", s, 32'h0);

        // Single job with latency bound.
        push_job(32'd7, 32'd100, 32'd14, 32'd2, 1'b1);
        wait_res(1, 60, cyc, ok);
        check("lat_ok", 32'(ok && cyc <= 40), 32'd1);
        rd(8'h08, s);
        check("dividend_readback", s, 32'd100);
        rd(8'h18, s);
        check("unmapped_read", s, 32'h0);
        drain_one("single");
        rd(8'h00, s);
        check("single_res_empty", 32'(s[2]), 32'd1);

        // Back-to-back jobs, results in order.
        push_job(32'd10, 32'd1000, 32'd100, 32'd0, 1'b1);
        push_job(32'd3, 32'd9, 32'd3, 32'd0, 1'b1);
        push_job(32'd9, 32'd5, 32'd0, 32'd5, 1'b1);
        push_job(32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1);
        wait_res(4, 250, cyc, ok);
        check("b2b_fill", 32'(ok), 32'd1);
        for (int i = 0; i < 4; i++) drain_one("b2b");

        // Stall the engine with a full result FIFO, then overflow the job FIFO.
        for (int i = 0; i < 4; i++) push_job(32'd8, 32'(40 + i), 32'd5, 32'(i), 1'b1);
        wait_res(4, 250, cyc, ok);
        check("ovf_res_fill", 32'(ok), 32'd1);
        for (int i = 4; i < 8; i++) push_job(32'd8, 32'(40 + i), 32'd5, 32'(i), 1'b1);
        push_job(32'd9, 32'd99, 32'd0, 32'd0, 1'b0);
        rd(8'h00, s);
        check("ovf_status", s, 32'h0004_042A);
        wr(8'h00, 32'h20);
        rd(8'h00, s);
        check("ovf_w1c", s, 32'h0004_040A);
        for (int i = 0; i < 8; i++) drain_one("ovf_drain");

        // POP on empty.
        wr(8'h14, 32'h0);
        rd(8'h00, s);
        check("unf_status", s, 32'h0000_0045);
        wr(8'h00, 32'h40);
        rd(8'h00, s);
        check("unf_w1c", s, 32'h0000_0005);

        // POP coincides with result enqueue.
        push_job(32'd3, 32'd6, 32'd2, 32'd0, 1'b1);
        wait_res(1, 60, cyc, ok);
        check("same_first", 32'(ok), 32'd1);
        push_job(32'd2, 32'd9, 32'd4, 32'd1, 1'b1);
        wait_div(8'h10, 80, ok);
        check("same_rdrem_seen", 32'(ok), 32'd1);
        wr(8'h14, 32'h0);
        rd(8'h00, s);
        check("same_res_count", 32'(s[23:16]), 32'd1);
        void'(sb.pop_front());
        drain_one("same_second");

        // Reset in the middle of polling.
        push_job(32'd10, 32'd1000, 32'd0, 32'd0, 1'b0);
        wait_div(8'h00, 40, ok);
        check("rst_poll_seen", 32'(ok), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_div_out", {dif.div_address, 22'h0, dif.div_we, dif.div_re}, 32'h0);
        check("rst_div_wdata", dif.div_write_data, 32'h0);
        rd(8'h00, s);
        check("rst_status", s, 32'h0000_0005);
        rd(8'h04, s);
        check("rst_divisor", s, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        push_job(32'd5, 32'd50, 32'd10, 32'd0, 1'b1);
        drain_one("after_rst");

        // Divide by zero.
        we_base = we_cnt;
        push_job(32'd0, 32'd77, 32'hFFFF_FFFF, 32'd77, 1'b1);
        wait_res(1, 60, cyc, ok);
        rd(8'h00, s);
`ifdef DIVQ_ZERO_BYPASS_EN
        check("dz_flag", 32'(s[7]), 32'd1);
        drain_one("dz");
        check("dz_div_we_pulses", 32'(we_cnt - we_base), 32'd0);
`else
        check("dz_flag", 32'(s[7]), 32'd0);
        drain_one("dz");
        check("dz_div_we_pulses", 32'(we_cnt - we_base), 32'd2);
`endif
        rd(8'h00, s);
        check("final_status", s, 32'h0000_0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
